// File: rtl/gen_bus_arbiter.sv
// Two-requester arbiter sharing one generic bus master port between instruction fetch (I)
// and load/store (D); D has priority, I starvation is bounded by MAX_D_STREAK.
module gen_bus_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int MAX_D_STREAK = 4
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                i_ren,
  input  logic [ADDR_W-1:0]   i_addr,
  output logic [DATA_W-1:0]   i_rdata,
  output logic                i_busy,
  input  logic                d_ren,
  input  logic                d_wen,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  input  logic [DATA_W/8-1:0] d_byte_en,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                d_busy,
  output logic                bus_ren,
  output logic                bus_wen,
  output logic [ADDR_W-1:0]   bus_addr,
  output logic [DATA_W-1:0]   bus_wdata,
  output logic [DATA_W/8-1:0] bus_byte_en,
  input  logic [DATA_W-1:0]   bus_rdata,
  input  logic                bus_busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_I = 2'd1,
    GNT_D = 2'd2
  } state_t;

  localparam logic [3:0] STREAK_MAX = 4'd15;
  localparam logic [3:0] STREAK_LIM = MAX_D_STREAK[3:0];

  state_t              r_state;
  logic [3:0]          r_streak;
  logic                r_bus_ren;
  logic                r_bus_wen;
  logic [ADDR_W-1:0]   r_bus_addr;
  logic [DATA_W-1:0]   r_bus_wdata;
  logic [DATA_W/8-1:0] r_bus_be;

  logic w_d_pend;
  logic w_i_pend;
  logic w_pick_d;
  logic w_pick_i;
  logic w_i_done;
  logic w_d_done;

  assign w_d_pend = d_ren | d_wen;
  assign w_i_pend = i_ren;
  // D wins unless I is also waiting and D has already had its quota of back-to-back grants.
  assign w_pick_d = w_d_pend & (~w_i_pend | (r_streak < STREAK_LIM));
  assign w_pick_i = w_i_pend & ~w_pick_d;

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state     <= IDLE;
      r_streak    <= 4'd0;
      r_bus_ren   <= 1'b0;
      r_bus_wen   <= 1'b0;
      r_bus_addr  <= '0;
      r_bus_wdata <= '0;
      r_bus_be    <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_pick_d) begin
            r_state     <= GNT_D;
            r_bus_ren   <= d_ren;
            r_bus_wen   <= d_wen & ~d_ren;
            r_bus_addr  <= d_addr;
            r_bus_wdata <= d_wdata;
            r_bus_be    <= d_byte_en;
            if (!i_ren)
              r_streak <= 4'd0;
            else if (r_streak != STREAK_MAX)
              r_streak <= r_streak + 4'd1;
          end else if (w_pick_i) begin
            r_state     <= GNT_I;
            r_bus_ren   <= 1'b1;
            r_bus_wen   <= 1'b0;
            r_bus_addr  <= i_addr;
            r_bus_wdata <= '0;
            r_bus_be    <= '1;
            r_streak    <= 4'd0;
          end
        end
        GNT_I, GNT_D: begin
          // The bus cannot abort, so the latch holds until completion regardless of the requester.
          if (!bus_busy) begin
            r_state     <= IDLE;
            r_bus_ren   <= 1'b0;
            r_bus_wen   <= 1'b0;
            r_bus_addr  <= '0;
            r_bus_wdata <= '0;
            r_bus_be    <= '0;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign w_i_done = (r_state == GNT_I) & ~bus_busy;
  assign w_d_done = (r_state == GNT_D) & ~bus_busy;

  assign i_busy  = ~w_i_done;
  assign d_busy  = ~w_d_done;
  assign i_rdata = w_i_done ? bus_rdata : '0;
  assign d_rdata = w_d_done ? bus_rdata : '0;

  assign bus_ren     = r_bus_ren;
  assign bus_wen     = r_bus_wen;
  assign bus_addr    = r_bus_addr;
  assign bus_wdata   = r_bus_wdata;
  assign bus_byte_en = r_bus_be;

endmodule
